// File: rtl/adder_sweep_seq.sv
// Stimulus sequencer and checker for 3-bit adders: sweeps every ordered pair of
// {a,b,c0} vectors, samples {c3,s} after SETTLE cycles and records mismatches.
module adder_sweep_seq #(
    parameter int SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  s_in,
    input  logic        c3_in,
    output logic [2:0]  a,
    output logic [2:0]  b,
    output logic        c0,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_cnt,
    output logic        fail_vld,
    output logic [6:0]  fail_from,
    output logic [6:0]  fail_to
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    state_t     state;
    state_t     state_next;
    logic [6:0] i;
    logic [6:0] j;
    logic [6:0] prev;
    logic       phase;
    logic [7:0] wc;
    logic [6:0] cur;
    logic [3:0] expected;
    logic       mismatch;
    logic       launch;
    logic       check;
    logic       last;

    assign cur      = {a, b, c0};
    assign expected = {1'b0, a} + {1'b0, b} + {3'b000, c0};
    assign mismatch = ({c3_in, s_in} != expected);
    assign launch   = start && (state != RUN);
    assign check    = (state == RUN) && (wc == SETTLE_LAST);
    assign last     = check && phase && (i == 7'd127) && (j == 7'd127);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // The last check leaves the operands on vector 127 instead of loading the wrapped i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {a, b, c0} <= 7'd0;
            i          <= 7'd0;
            j          <= 7'd0;
            prev       <= 7'd0;
            phase      <= 1'b0;
            wc         <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_cnt    <= 16'd0;
            fail_vld   <= 1'b0;
            fail_from  <= 7'd0;
            fail_to    <= 7'd0;
        end else if (launch) begin
            {a, b, c0} <= 7'd0;
            i          <= 7'd0;
            j          <= 7'd0;
            prev       <= 7'd0;
            phase      <= 1'b0;
            wc         <= 8'd0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err_cnt    <= 16'd0;
            fail_vld   <= 1'b0;
            fail_from  <= 7'd0;
            fail_to    <= 7'd0;
        end else if (state == RUN) begin
            if (!check) begin
                wc <= wc + 8'd1;
            end else begin
                wc   <= 8'd0;
                prev <= cur;
                if (mismatch) begin
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                    if (!fail_vld) begin
                        fail_vld  <= 1'b1;
                        fail_from <= prev;
                        fail_to   <= cur;
                    end
                end
                if (!phase) begin
                    {a, b, c0} <= j;
                    phase      <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    j     <= j + 7'd1;
                    if (j == 7'd127) i <= i + 7'd1;
                    if (last) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else if (j == 7'd127) begin
                        {a, b, c0} <= i + 7'd1;
                    end else begin
                        {a, b, c0} <= i;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_sweep_seq.sv
// Bench for adder_sweep_seq: a behavioural adder with a random fault table sits
// around the sequencer, and a sweep-order model predicts schedule and results.
module tb_adder_sweep_seq;

    localparam int SETTLE  = 2;
    localparam int NCHECKS = 32768;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  s_in;
    logic        c3_in;
    logic [2:0]  a;
    logic [2:0]  b;
    logic        c0;
    logic        busy;
    logic        done;
    logic [15:0] err_cnt;
    logic        fail_vld;
    logic [6:0]  fail_from;
    logic [6:0]  fail_to;

    logic [3:0]  fault_tbl [128];
    logic        fault_on;
    logic [3:0]  sum_ok;

    int compared;
    int mismatched;

    adder_sweep_seq #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_in(s_in), .c3_in(c3_in),
        .a(a), .b(b), .c0(c0), .busy(busy), .done(done), .err_cnt(err_cnt),
        .fail_vld(fail_vld), .fail_from(fail_from), .fail_to(fail_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder under test: a correct sum, optionally corrupted per input vector.
    always_comb begin
        sum_ok = {1'b0, a} + {1'b0, b} + {3'b000, c0};
        {c3_in, s_in} = fault_on ? (sum_ok ^ fault_tbl[{a, b, c0}]) : sum_ok;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Vector applied for the k-th check of a sweep: pairs (i,j) in order, i then j.
    function automatic logic [6:0] vec_at(input int k);
        int p;
        p = k / 2;
        if (k >= NCHECKS) return 7'd127;
        return (k % 2 == 1) ? 7'(p % 128) : 7'(p / 128);
    endfunction

    function automatic logic [3:0] true_sum(input logic [6:0] v);
        return {1'b0, v[6:4]} + {1'b0, v[3:1]} + {3'b000, v[0]};
    endfunction

    // Results expected after the first n checks of a sweep.
    task automatic model(input int n, input logic faulty, output int errs,
                         output logic vld, output logic [6:0] from_v, output logic [6:0] to_v);
        logic [6:0] v;
        logic [6:0] pv;
        logic [3:0] got;
        errs = 0; vld = 1'b0; from_v = 7'd0; to_v = 7'd0; pv = 7'd0;
        for (int k = 0; k < n; k++) begin
            v   = vec_at(k);
            got = faulty ? (true_sum(v) ^ fault_tbl[v]) : true_sum(v);
            if (got != true_sum(v)) begin
                errs++;
                if (!vld) begin
                    vld = 1'b1; from_v = pv; to_v = v;
                end
            end
            pv = v;
        end
    endtask

    task automatic check_results(input string tag, input int n, input logic faulty);
        int         errs;
        logic       vld;
        logic [6:0] fv;
        logic [6:0] tv;
        model(n, faulty, errs, vld, fv, tv);
        check_output({tag, "_err_cnt"}, 32'(err_cnt), 32'(errs));
        check_output({tag, "_fail_vld"}, 32'(fail_vld), 32'(vld));
        check_output({tag, "_fail_from"}, 32'(fail_from), 32'(fv));
        check_output({tag, "_fail_to"}, 32'(fail_to), 32'(tv));
    endtask

    task automatic check_idle_zero(input string tag);
        check_output({tag, "_all"},
                     {a, b, c0, busy, done, fail_vld, fail_from, fail_to},
                     32'd0);
        check_output({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    // After t edges from E0: {busy, done, operand vector}.
    function automatic logic [8:0] sched_at(input int t);
        int n;
        n = t / SETTLE;
        if (n >= NCHECKS) return {1'b0, 1'b1, 7'd127};
        return {1'b1, 1'b0, vec_at(n)};
    endfunction

    task automatic applyStimulus(input logic go);
        start = go;
        tick();
        start = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        fault_on   = 1'b1;
        for (int v = 0; v < 128; v++)
            fault_tbl[v] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        fault_tbl[$urandom_range(1, 127)] = 4'($urandom_range(1, 15));

        tick();
        tick();
        check_idle_zero("reset");
        rst_n = 1'b1;
        tick();
        tick();
        check_idle_zero("idle");

        // Partial sweep with an ignored start mid-run, then an asynchronous reset.
        applyStimulus(1'b1);
        check_output("e0_sched", 32'({busy, done, a, b, c0}), 32'(sched_at(0)));
        check_output("e0_err_cnt", 32'(err_cnt), 32'd0);
        for (int t = 1; t <= 1000; t++) begin
            applyStimulus(t == 500);
            check_output("run1_sched", 32'({busy, done, a, b, c0}), 32'(sched_at(t)));
        end
        check_results("run1", 1000 / SETTLE, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_idle_zero("async_reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_idle_zero("post_reset");

        // Full faulted sweep.
        applyStimulus(1'b1);
        check_output("run2_e0_sched", 32'({busy, done, a, b, c0}), 32'(sched_at(0)));
        for (int t = 1; t <= NCHECKS * SETTLE; t++) begin
            tick();
            check_output("run2_sched", 32'({busy, done, a, b, c0}), 32'(sched_at(t)));
        end
        check_results("run2_final", NCHECKS, 1'b1);
        for (int t = 0; t < 3; t++) tick();
        check_output("done_hold", 32'({busy, done, a, b, c0}), {23'd0, 2'b01, 7'd127});
        check_results("run2_hold", NCHECKS, 1'b1);

        // Restart from DONE with a clean adder.
        fault_on = 1'b0;
        applyStimulus(1'b1);
        check_output("restart_sched", 32'({busy, done, a, b, c0}), 32'(sched_at(0)));
        check_results("restart_e0", 0, 1'b0);
        for (int t = 1; t <= 2000; t++) begin
            tick();
            check_output("run3_sched", 32'({busy, done, a, b, c0}), 32'(sched_at(t)));
        end
        check_results("run3", 2000 / SETTLE, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
